// File: rtl/frame_bridge.sv
// frame_bridge: collects DATA_W-bit words into a NUM_WORDS-word frame register,
// shifting LSB-first or MSB-first. It presents the completed frame with a
// valid/ready handshake and raises a sticky overflow flag when a word is
// dropped while a frame is still waiting to be consumed.
module frame_bridge #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 66,
  parameter int SHIFT_DIR = 0,
  parameter int CNT_W     = $clog2(NUM_WORDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        shift_en,
  input  logic                        clear,
  input  logic                        frame_ready,
  output logic [DATA_W*NUM_WORDS-1:0] data_out,
  output logic                        frame_valid,
  output logic [CNT_W-1:0]            word_count,
  output logic                        overflow
);

  localparam int FRAME_W = DATA_W * NUM_WORDS;

  typedef enum logic {FILL, FULL} state_t;

  state_t state;

  // Insert one word into a frame. Direction 0 enters at the bottom and pushes
  // older words up; direction 1 enters at the top and pushes older words down.
  function automatic logic [FRAME_W-1:0] shift_word(
    input logic [FRAME_W-1:0] cur,
    input logic [DATA_W-1:0]  w
  );
    logic [FRAME_W-1:0] res;
    if (SHIFT_DIR == 0) begin
      res = {cur[FRAME_W-DATA_W-1:0], w};
    end else begin
      res = {w, cur[FRAME_W-1:DATA_W]};
    end
    return res;
  endfunction

  // The state register is itself a flop, so frame_valid has no input-to-output path.
  assign frame_valid = (state == FULL);

  // Frame assembly, handshake and overflow tracking; clear outranks everything but rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      data_out   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= FILL;
      data_out   <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (shift_en) begin
            data_out   <= shift_word(data_out, data_in);
            word_count <= word_count + CNT_W'(1);
            if (word_count == CNT_W'(NUM_WORDS - 1)) begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (frame_ready) begin
            // A word arriving on the handshake cycle starts the next frame
            // rather than being dropped, so back-to-back frames lose nothing.
            state <= FILL;
            if (shift_en) begin
              data_out   <= shift_word('0, data_in);
              word_count <= CNT_W'(1);
            end else begin
              data_out   <= '0;
              word_count <= '0;
            end
          end else if (shift_en) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_bridge.sv
// Testbench for frame_bridge: one default-size instance for the legacy check
// and two 4-word instances (LSB-first and MSB-first) sharing the same stimulus.
module tb_frame_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       shift_en;
  logic       clear;
  logic       frame_ready;

  logic [527:0] a_data;
  logic         a_fv;
  logic [6:0]   a_cnt;
  logic         a_ov;

  logic [31:0] b_data;
  logic        b_fv;
  logic [2:0]  b_cnt;
  logic        b_ov;

  logic [31:0] c_data;
  logic        c_fv;
  logic [2:0]  c_cnt;
  logic        c_ov;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_bridge u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_en(shift_en), .clear(clear),
    .frame_ready(frame_ready), .data_out(a_data), .frame_valid(a_fv),
    .word_count(a_cnt), .overflow(a_ov)
  );

  frame_bridge #(.DATA_W(8), .NUM_WORDS(4), .SHIFT_DIR(0)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_en(shift_en), .clear(clear),
    .frame_ready(frame_ready), .data_out(b_data), .frame_valid(b_fv),
    .word_count(b_cnt), .overflow(b_ov)
  );

  frame_bridge #(.DATA_W(8), .NUM_WORDS(4), .SHIFT_DIR(1)) u_c (
    .clk(clk), .rst(rst), .data_in(data_in), .shift_en(shift_en), .clear(clear),
    .frame_ready(frame_ready), .data_out(c_data), .frame_valid(c_fv),
    .word_count(c_cnt), .overflow(c_ov)
  );

  typedef struct {
    logic        sh;
    logic [7:0]  d;
    logic        clr;
    logic        rdy;
    logic [31:0] eb;
    logic [2:0]  cnt;
    logic        vld;
    logic        ovf;
    logic [31:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic sh, input logic [7:0] d, input logic clr,
                             input logic rdy, input logic [31:0] eb, input logic [2:0] cnt,
                             input logic vld, input logic ovf, input logic [31:0] ec);
    vec_t r;
    r.sh = sh; r.d = d; r.clr = clr; r.rdy = rdy;
    r.eb = eb; r.cnt = cnt; r.vld = vld; r.ovf = ovf; r.ec = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [527:0] act, input logic [527:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic sh, input logic [7:0] d, input logic clr, input logic rdy);
    @(negedge clk);
    shift_en = sh; data_in = d; clear = clr; frame_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_small(input string tag, input logic [31:0] eb, input logic [2:0] cnt,
                           input logic vld, input logic ovf, input logic [31:0] ec);
    chk({tag, " b_data"}, b_data, eb);
    chk({tag, " b_cnt"},  b_cnt,  cnt);
    chk({tag, " b_vld"},  b_fv,   vld);
    chk({tag, " b_ovf"},  b_ov,   ovf);
    chk({tag, " c_data"}, c_data, ec);
    chk({tag, " c_cnt"},  c_cnt,  cnt);
    chk({tag, " c_vld"},  c_fv,   vld);
  endtask

  initial begin
    rst = 1'b1; shift_en = 1'b0; data_in = 8'h00; clear = 1'b0; frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset a_data", a_data, '0);
    chk("reset a_cnt", a_cnt, 7'd0);
    chk("reset a_vld", a_fv, 1'b0);
    chk("reset a_ovf", a_ov, 1'b0);
    chk_small("reset", 32'h0, 3'd0, 1'b0, 1'b0, 32'h0);

    // Legacy default-size behaviour
    step(1'b1, 8'h81, 1'b0, 1'b0);
    chk("legacy1 a_data", a_data, {520'b0, 8'h81});
    chk("legacy1 a_cnt", a_cnt, 7'd1);
    step(1'b1, 8'h81, 1'b0, 1'b0);
    chk("legacy2 a_data", a_data, {512'b0, 8'h81, 8'h81});
    chk("legacy2 a_cnt", a_cnt, 7'd2);
    chk("legacy2 a_vld", a_fv, 1'b0);
    chk("legacy2 c_data", c_data, 32'h81810000);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("legacy clr a_data", a_data, '0);
    chk("legacy clr a_cnt", a_cnt, 7'd0);

    // sh, d, clr, rdy, b_data, cnt, vld, ovf, c_data
    tbl.push_back(v(1, 8'h11, 0, 0, 32'h00000011, 3'd1, 0, 0, 32'h11000000));
    tbl.push_back(v(1, 8'h22, 0, 0, 32'h00001122, 3'd2, 0, 0, 32'h22110000));
    tbl.push_back(v(1, 8'h33, 0, 0, 32'h00112233, 3'd3, 0, 0, 32'h33221100));
    tbl.push_back(v(1, 8'h44, 0, 0, 32'h11223344, 3'd4, 1, 0, 32'h44332211));
    tbl.push_back(v(1, 8'h55, 0, 0, 32'h11223344, 3'd4, 1, 1, 32'h44332211));
    tbl.push_back(v(0, 8'h00, 0, 0, 32'h11223344, 3'd4, 1, 1, 32'h44332211));
    tbl.push_back(v(1, 8'h66, 1, 1, 32'h00000000, 3'd0, 0, 0, 32'h00000000));
    tbl.push_back(v(1, 8'h11, 0, 0, 32'h00000011, 3'd1, 0, 0, 32'h11000000));
    tbl.push_back(v(1, 8'h22, 0, 1, 32'h00001122, 3'd2, 0, 0, 32'h22110000));
    tbl.push_back(v(1, 8'h33, 0, 0, 32'h00112233, 3'd3, 0, 0, 32'h33221100));
    tbl.push_back(v(1, 8'h44, 0, 0, 32'h11223344, 3'd4, 1, 0, 32'h44332211));
    tbl.push_back(v(1, 8'h55, 0, 0, 32'h11223344, 3'd4, 1, 1, 32'h44332211));
    tbl.push_back(v(1, 8'hAA, 0, 1, 32'h000000AA, 3'd1, 0, 1, 32'hAA000000));
    tbl.push_back(v(0, 8'h00, 0, 1, 32'h000000AA, 3'd1, 0, 1, 32'hAA000000));
    tbl.push_back(v(1, 8'hBB, 0, 1, 32'h0000AABB, 3'd2, 0, 1, 32'hBBAA0000));
    tbl.push_back(v(1, 8'hCC, 0, 0, 32'h00AABBCC, 3'd3, 0, 1, 32'hCCBBAA00));
    tbl.push_back(v(1, 8'hDD, 0, 0, 32'hAABBCCDD, 3'd4, 1, 1, 32'hDDCCBBAA));
    tbl.push_back(v(0, 8'h00, 0, 1, 32'h00000000, 3'd0, 0, 1, 32'h00000000));
    tbl.push_back(v(0, 8'h00, 1, 0, 32'h00000000, 3'd0, 0, 0, 32'h00000000));
    tbl.push_back(v(1, 8'h01, 0, 1, 32'h00000001, 3'd1, 0, 0, 32'h01000000));
    tbl.push_back(v(1, 8'h02, 0, 1, 32'h00000102, 3'd2, 0, 0, 32'h02010000));
    tbl.push_back(v(1, 8'h03, 0, 1, 32'h00010203, 3'd3, 0, 0, 32'h03020100));
    tbl.push_back(v(1, 8'h04, 0, 1, 32'h01020304, 3'd4, 1, 0, 32'h04030201));
    tbl.push_back(v(1, 8'h05, 0, 1, 32'h00000005, 3'd1, 0, 0, 32'h05000000));
    tbl.push_back(v(1, 8'h06, 0, 1, 32'h00000506, 3'd2, 0, 0, 32'h06050000));
    tbl.push_back(v(1, 8'h07, 0, 1, 32'h00050607, 3'd3, 0, 0, 32'h07060500));
    tbl.push_back(v(1, 8'h08, 0, 1, 32'h05060708, 3'd4, 1, 0, 32'h08070605));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].sh, tbl[i].d, tbl[i].clr, tbl[i].rdy);
      chk_small($sformatf("row%0d", i), tbl[i].eb, tbl[i].cnt, tbl[i].vld,
                tbl[i].ovf, tbl[i].ec);
    end

    // Async reset between edges, mid-frame
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    chk_small("pre_rst", 32'h00000102, 3'd2, 1'b0, 1'b0, 32'h02010000);
    @(negedge clk);
    shift_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_small("async_rst", 32'h0, 3'd0, 1'b0, 1'b0, 32'h0);
    chk("async_rst a_cnt", a_cnt, 7'd0);
    chk("async_rst a_data", a_data, '0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    chk_small("refill3", 32'h000A0B0C, 3'd3, 1'b0, 1'b0, 32'h0C0B0A00);
    step(1'b1, 8'h0D, 1'b0, 1'b0);
    chk_small("refill4", 32'h0A0B0C0D, 3'd4, 1'b1, 1'b0, 32'h0D0C0B0A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
